// File: rtl/modexp_pkg.sv
// Shared definitions for the ModExp operand/result sequencer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Contents: controller state encoding, core COMPLETE status code, word-slice helper.
package modexp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_NPRIME = 3'd1,
      ST_LOAD   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_READ   = 3'd4
   } state_e;

   // exp_state value reported by the core once the exponentiation has finished
   localparam logic [4:0] EXP_COMPLETE = 5'd9;

   // Bit offset of word idx inside a bus built from width-bit words, LSW at bit 0.
   function automatic int word_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/mont_nprime_calc.sv
// Montgomery constant n' = -n0^-1 mod 2^W via a Hensel lift, one bit per cycle.
// Latency: go loads n0, then W-1 iteration cycles; valid marks the last one.
// Backpressure: none; go is only honoured as a fresh job and restarts the lift.
// Ports: clk, rst (sync, active high), go/n0 in; busy, valid, nprime, even_err out.
module mont_nprime_calc #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         go,
   input  logic [W-1:0] n0,
   output logic         busy,
   output logic         valid,
   output logic [W-1:0] nprime,
   output logic         even_err
);

   localparam int             IW       = $clog2(W);
   localparam logic [IW-1:0]  LAST_BIT = IW'(W - 1);

   logic          busy_q, busy_d;
   logic [W-1:0]  n0_q, n0_d;
   logic [W-1:0]  y_q, y_d;      // running inverse of n0
   logic [W-1:0]  p_q, p_d;      // n0 * y mod 2^W, kept == 1 on the low i bits
   logic [IW-1:0] i_q, i_d;

   always_comb begin
      busy_d = busy_q;
      n0_d   = n0_q;
      y_d    = y_q;
      p_d    = p_q;
      i_d    = i_q;
      if (go) begin
         busy_d = 1'b1;
         n0_d   = n0;
         y_d    = W'(1);
         p_d    = n0;
         i_d    = IW'(1);
      end else if (busy_q) begin
         // A set bit i in the product is cleared by adding n0 * 2^i (n0 odd).
         if (p_q[i_q]) begin
            y_d[i_q] = 1'b1;
            p_d      = p_q + (n0_q << i_q);
         end
         i_d = i_q + 1'b1;
         if (i_q == LAST_BIT) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         n0_q   <= '0;
         y_q    <= '0;
         p_q    <= '0;
         i_q    <= '0;
      end else begin
         busy_q <= busy_d;
         n0_q   <= n0_d;
         y_q    <= y_d;
         p_q    <= p_d;
         i_q    <= i_d;
      end
   end

   assign busy     = busy_q;
   assign valid    = busy_q && (i_q == LAST_BIT);
   // Taken from y_d so the final inverse is available in the valid cycle itself.
   assign nprime   = ~y_d + W'(1);
   assign even_err = ~n0_q[0];

endmodule

// File: rtl/modexp_stream_ctrl.sv
// Operand/result sequencer between a wide host bus and the word-serial ModExp core.
// Latency: W + 2*DATA_NUMBER + RD_LAT + 2 cycles plus core compute time.
// Backpressure: start is ignored unless IDLE; core completion only honoured in WAIT.
// Ports: clk/rst, start + five RSA_WIDTH operands in; busy/done/err/cypher/mod_inv out;
//        core side: operand word buses, nprime0, startInput/startCompute/getResult out,
//        exp_state/res_out in.
module modexp_stream_ctrl
   import modexp_pkg::*;
#(
   parameter int RSA_WIDTH   = 4096,
   parameter int DATA_WIDTH  = 128,
   parameter int DATA_NUMBER = RSA_WIDTH / DATA_WIDTH,
   parameter int RD_LAT      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [RSA_WIDTH-1:0]  message,
   input  logic [RSA_WIDTH-1:0]  exponent,
   input  logic [RSA_WIDTH-1:0]  modulus,
   input  logic [RSA_WIDTH-1:0]  r_mod,
   input  logic [RSA_WIDTH-1:0]  r2_mod,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [RSA_WIDTH-1:0]  cypher,
   output logic [DATA_WIDTH-1:0] mod_inv,
   output logic [DATA_WIDTH-1:0] m_buf,
   output logic [DATA_WIDTH-1:0] e_buf,
   output logic [DATA_WIDTH-1:0] n_buf,
   output logic [DATA_WIDTH-1:0] r_buf,
   output logic [DATA_WIDTH-1:0] t_buf,
   output logic [DATA_WIDTH-1:0] nprime0,
   output logic                  startInput,
   output logic                  startCompute,
   output logic                  getResult,
   input  logic [4:0]            exp_state,
   input  logic [DATA_WIDTH-1:0] res_out
);

   localparam int               CNT_W     = $clog2(DATA_NUMBER) + 1;
   localparam logic [CNT_W-1:0] DN_C      = CNT_W'(DATA_NUMBER);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DATA_NUMBER - 1);

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [RSA_WIDTH-1:0]        msg_q, msg_d, exp_q, exp_d, mod_q, mod_d, r_q, r_d, r2_q, r2_d;
   logic                        busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [RSA_WIDTH-1:0]        cypher_q, cypher_d;
   logic [DATA_WIDTH-1:0]       mod_inv_q, mod_inv_d;
   // getResult strobes delayed by RD_LAT so each returning word knows its slot
   logic [RD_LAT-1:0]           rd_vld_q, rd_vld_d;
   logic [RD_LAT-1:0][CNT_W-1:0] rd_idx_q, rd_idx_d;

   logic                        go, np_busy, np_valid, np_even;
   logic [DATA_WIDTH-1:0]       np_nprime;
   logic                        start_input, start_compute, get_result;
   logic [CNT_W-1:0]            ld_idx, cap_idx;
   logic                        cap_vld;
   int                          ld_lsb;

   assign go = (state_q == ST_IDLE) && start;

   mont_nprime_calc #(.W(DATA_WIDTH)) u_nprime (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .n0       (modulus[DATA_WIDTH-1:0]),
      .busy     (np_busy),
      .valid    (np_valid),
      .nprime   (np_nprime),
      .even_err (np_even)
   );

   // LOAD runs cnt 0..DATA_NUMBER-1 for words, then one extra cycle for startCompute.
   always_comb begin
      start_input   = (state_q == ST_LOAD) && (cnt_q < DN_C);
      start_compute = (state_q == ST_LOAD) && (cnt_q == DN_C);
      get_result    = (state_q == ST_READ) && (cnt_q < DN_C) && !done_q;
      ld_idx        = start_input ? cnt_q : '0;
      ld_lsb        = word_lsb(int'(ld_idx), DATA_WIDTH);
      cap_vld       = rd_vld_q[RD_LAT-1];
      cap_idx       = rd_idx_q[RD_LAT-1];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      msg_d     = msg_q;
      exp_d     = exp_q;
      mod_d     = mod_q;
      r_d       = r_q;
      r2_d      = r2_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      cypher_d  = cypher_q;
      mod_inv_d = mod_inv_q;

      rd_vld_d[0] = get_result;
      rd_idx_d[0] = cnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
         rd_vld_d[i] = rd_vld_q[i-1];
         rd_idx_d[i] = rd_idx_q[i-1];
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               msg_d   = message;
               exp_d   = exponent;
               mod_d   = modulus;
               r_d     = r_mod;
               r2_d    = r2_mod;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_NPRIME;
            end
         end
         ST_NPRIME: begin
            // An even modulus finishes here; done is shown before IDLE so a
            // start coinciding with done cannot be taken.
            if (done_q) begin
               state_d = ST_IDLE;
            end else if (np_busy && np_valid) begin
               mod_inv_d = np_nprime;
               cnt_d     = '0;
               if (np_even) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
                  busy_d = 1'b0;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (cnt_q == DN_C) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (exp_state == EXP_COMPLETE) begin
               cnt_d   = '0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (done_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q < DN_C) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (cap_vld) begin
               cypher_d[word_lsb(int'(cap_idx), DATA_WIDTH) +: DATA_WIDTH] = res_out;
               if (cap_idx == LAST_WORD) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         msg_q     <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         r_q       <= '0;
         r2_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cypher_q  <= '0;
         mod_inv_q <= '0;
         rd_vld_q  <= '0;
         rd_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         msg_q     <= msg_d;
         exp_q     <= exp_d;
         mod_q     <= mod_d;
         r_q       <= r_d;
         r2_q      <= r2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cypher_q  <= cypher_d;
         mod_inv_q <= mod_inv_d;
         rd_vld_q  <= rd_vld_d;
         rd_idx_q  <= rd_idx_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign cypher       = cypher_q;
   assign mod_inv      = mod_inv_q;
   assign nprime0      = mod_inv_q;
   assign startInput   = start_input;
   assign startCompute = start_compute;
   assign getResult    = get_result;
   assign m_buf        = start_input ? msg_q[ld_lsb +: DATA_WIDTH] : '0;
   assign e_buf        = start_input ? exp_q[ld_lsb +: DATA_WIDTH] : '0;
   assign n_buf        = start_input ? mod_q[ld_lsb +: DATA_WIDTH] : '0;
   assign r_buf        = start_input ? r_q[ld_lsb +: DATA_WIDTH]   : '0;
   assign t_buf        = start_input ? r2_q[ld_lsb +: DATA_WIDTH]  : '0;

endmodule

// File: tb/tb_modexp_stream_ctrl.sv
// Directed + randomized bench for modexp_stream_ctrl with an inline core model.
// Latency: checks acceptance-to-LOAD, LOAD length, READ length and done timing.
// Backpressure: exercises start while busy, start across done, spurious completion.
module tb_modexp_stream_ctrl;

   localparam int W      = 8;
   localparam int RSA    = 32;
   localparam int DN     = RSA / W;
   localparam int RD_LAT = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [RSA-1:0] message, exponent, modulus, r_mod, r2_mod;
   logic           busy, done, err;
   logic [RSA-1:0] cypher;
   logic [W-1:0]   mod_inv, m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
   logic           startInput, startCompute, getResult;
   logic [4:0]     exp_state;
   logic [W-1:0]   res_out;

   int             n_assert = 0;
   int             n_fail   = 0;
   logic [RSA-1:0] model_cypher;

   modexp_stream_ctrl #(.RSA_WIDTH(RSA), .DATA_WIDTH(W), .DATA_NUMBER(DN), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .message(message), .exponent(exponent), .modulus(modulus), .r_mod(r_mod), .r2_mod(r2_mod),
      .busy(busy), .done(done), .err(err), .cypher(cypher), .mod_inv(mod_inv),
      .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
      .nprime0(nprime0), .startInput(startInput), .startCompute(startCompute),
      .getResult(getResult), .exp_state(exp_state), .res_out(res_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // n' by exhaustive search for the inverse rather than by bit-serial lifting.
   function automatic logic [W-1:0] model_minv(input logic [W-1:0] n0);
      for (int y = 0; y < (1 << W); y++) begin
         if (((int'(n0) * y) % (1 << W)) == 1) return W'(((1 << W) - y) % (1 << W));
      end
      return '0;
   endfunction

   task automatic run_job(input logic [RSA-1:0] msg, ex, md, rr, r2, res,
                          input bit hold_start, input bit spurious, input int abort_word);
      int       c;
      int       strobes;
      int       pidx;
      bit       pend;
      message = msg; exponent = ex; modulus = md; r_mod = rr; r2_mod = r2;
      start = 1'b1;
      @(negedge clk);
      c = 1;
      if (!hold_start) start = 1'b0;
      // operands must have been captured at acceptance, not followed afterwards
      message = $urandom(); exponent = $urandom(); modulus = $urandom();
      r_mod = $urandom(); r2_mod = $urandom();
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("err_cleared_on_accept", 32'(err), 32'd0);

      if (md[0] == 1'b0) begin
         while (!done && c < 100) begin
            chk("even_no_startInput", 32'(startInput), 32'd0);
            @(negedge clk);
            c++;
         end
         chk("even_done_latency", 32'(c), 32'(W));
         chk("even_err", 32'(err), 32'd1);
         chk("even_cypher_kept", cypher, model_cypher);
         chk("even_busy_low", 32'(busy), 32'd0);
         @(negedge clk);
         chk("even_done_pulse", 32'(done), 32'd0);
         start = 1'b0;
         return;
      end

      while (!startInput && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("load_latency", 32'(c), 32'(W));
      chk("mod_inv", 32'(mod_inv), 32'(model_minv(md[W-1:0])));
      chk("nprime0", 32'(nprime0), 32'(model_minv(md[W-1:0])));
      if (spurious) exp_state = 5'd9;

      for (int k = 0; k < DN; k++) begin
         if (k == abort_word) begin
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_startInput", 32'(startInput), 32'd0);
            chk("rst_m_buf", 32'(m_buf), 32'd0);
            chk("rst_n_buf", 32'(n_buf), 32'd0);
            chk("rst_startCompute", 32'(startCompute), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_mod_inv", 32'(mod_inv), 32'd0);
            rst = 1'b0;
            exp_state = 5'd0;
            model_cypher = '0;
            @(negedge clk);
            chk("post_rst_idle", 32'(busy), 32'd0);
            return;
         end
         chk("load_startInput", 32'(startInput), 32'd1);
         chk("load_startCompute_low", 32'(startCompute), 32'd0);
         chk("load_m_buf", 32'(m_buf), 32'(msg[k*W +: W]));
         chk("load_e_buf", 32'(e_buf), 32'(ex[k*W +: W]));
         chk("load_n_buf", 32'(n_buf), 32'(md[k*W +: W]));
         chk("load_r_buf", 32'(r_buf), 32'(rr[k*W +: W]));
         chk("load_t_buf", 32'(t_buf), 32'(r2[k*W +: W]));
         @(negedge clk);
      end
      chk("startCompute_pulse", 32'(startCompute), 32'd1);
      chk("startInput_off", 32'(startInput), 32'd0);
      exp_state = 5'd0;
      @(negedge clk);
      chk("startCompute_once", 32'(startCompute), 32'd0);
      repeat (49) @(negedge clk);
      chk("wait_no_getResult", 32'(getResult), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);

      exp_state = 5'd9;
      c = 0; strobes = 0; pend = 1'b0; pidx = 0;
      while (!done && c < 200) begin
         @(negedge clk);
         c++;
         // core returns word RD_LAT(=1) cycle after its strobe, junk otherwise
         res_out = pend ? res[pidx*W +: W] : W'($urandom());
         pend = getResult;
         if (getResult) begin
            pidx = strobes;
            strobes++;
         end
      end
      exp_state = 5'd0;
      model_cypher = res;
      chk("read_to_done_cycles", 32'(c), 32'(DN + RD_LAT + 1));
      chk("getResult_strobes", 32'(strobes), 32'(DN));
      chk("cypher", cypher, model_cypher);
      chk("busy_falls_with_done", 32'(busy), 32'd0);
      chk("err_ok", 32'(err), 32'd0);
      @(negedge clk);
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("no_accept_during_done", 32'(busy), 32'd0);
      start = 1'b0;
      @(negedge clk);
      chk("idle_after_job", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [RSA-1:0] md, res;
      rst = 1'b1; start = 1'b0; exp_state = 5'd0; res_out = '0;
      message = '0; exponent = '0; modulus = '0; r_mod = '0; r2_mod = '0;
      model_cypher = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_cypher", cypher, 32'd0);
      chk("reset_mod_inv", 32'(mod_inv), 32'd0);
      chk("reset_ctrl", {29'd0, startInput, startCompute, getResult}, 32'd0);
      chk("reset_bufs", {m_buf, e_buf, n_buf, t_buf}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // directed: n0 = 3, known message/result words, start held, spurious COMPLETE in LOAD
      md = $urandom(); md[7:0] = 8'h03;
      run_job(32'h44332211, $urandom(), md, $urandom(), $urandom(), 32'hA4A3A2A1, 1'b1, 1'b1, -1);
      chk("n0_3_inv", 32'(model_minv(8'h03)), 32'h55);

      md = $urandom(); md[7:0] = 8'h01;
      res = $urandom();
      run_job($urandom(), $urandom(), md, $urandom(), $urandom(), res, 1'b0, 1'b0, -1);

      md = $urandom(); md[7:0] = 8'h10;
      run_job($urandom(), $urandom(), md, $urandom(), $urandom(), $urandom(), 1'b0, 1'b0, -1);

      // abort in LOAD at word 2, then normal jobs with random odd moduli
      md = $urandom() | 32'd1;
      run_job($urandom(), $urandom(), md, $urandom(), $urandom(), $urandom(), 1'b0, 1'b0, 2);
      chk("cypher_after_rst", cypher, model_cypher);

      for (int j = 0; j < 4; j++) begin
         md  = $urandom() | 32'd1;
         res = $urandom();
         run_job($urandom(), $urandom(), md, $urandom(), $urandom(), res,
                 1'(j % 2), 1'(j / 2), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
